// File: rtl/pulse_rate_meter_pkg.sv
// -----------------------------------------------------------------------------
// pulse_rate_meter_pkg
// Shared definitions for the pulse rate meter (receive side of the irrigation
// clock-division chain): FSM state encoding, default window/counter sizing and
// the nominal edge counts expected from the divided lines over one window.
// No ports.
// -----------------------------------------------------------------------------
package pulse_rate_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GATE  = 2'd1,
    ST_LATCH = 2'd2
  } state_t;

  // 224 cycles of the 224 Hz system clock is a one-second window.
  localparam int GATE_CYCLES_1S = 224;
  localparam int DEF_CNT_W      = 8;

  // Nominal line rates of the divided clocks read back by the meter.
  localparam int SPRINKLER_HZ = 28;
  localparam int FILL_HZ      = 14;
  localparam int DRIP_HZ      = 7;

  // Edge count a line of rate_hz produces over a window of gate_cycles.
  function automatic int expected_count(input int rate_hz, input int gate_cycles);
    return (rate_hz * gate_cycles) / GATE_CYCLES_1S;
  endfunction

  localparam int SPRINKLER_CNT_1S = SPRINKLER_HZ;
  localparam int FILL_CNT_1S      = FILL_HZ;
  localparam int DRIP_CNT_1S      = DRIP_HZ;

endpackage

// File: rtl/pulse_rate_meter_edge_sync.sv
// -----------------------------------------------------------------------------
// pulse_rate_meter_edge_sync
// Brings the asynchronous pulse line into the clk_224hz domain through a
// SYNC_STAGES-deep flop chain, then keeps a one-flop history of the
// synchronized level to detect rising edges.
// Ports:
//   i_clk    system clock (rising edge)
//   i_clear  synchronous active-high clear, zeroes chain and history
//   i_pulse  asynchronous line under measurement
//   o_sync   synchronized level
//   o_rise   synchronized level high while history is low
// -----------------------------------------------------------------------------
module pulse_rate_meter_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_clear,
  input  logic i_pulse,
  output logic o_sync,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;

  // History tracks the synchronized level unconditionally, so a line that is
  // already high when a window opens never reads as a fresh edge.
  always_ff @(posedge i_clk) begin
    if (i_clear) begin
      r_sync <= '0;
      r_hist <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_pulse};
      r_hist <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_sync = r_sync[SYNC_STAGES-1];
  assign o_rise = r_sync[SYNC_STAGES-1] & ~r_hist;

endmodule

// File: rtl/pulse_rate_meter.sv
// -----------------------------------------------------------------------------
// pulse_rate_meter
// Counts rising edges of a slow pulse line over a fixed window of GATE_CYCLES
// system clocks, publishes the count with a one-cycle valid strobe and flags
// whether it lies in the programmable [min_count, max_count] band.
// Ports:
//   clk_224hz    system clock (rising edge)
//   clear        synchronous active-high reset, highest priority
//   enable       run/stop request for measurement windows
//   pulse_in     asynchronous line under measurement
//   min_count    inclusive lower band limit, sampled when the result latches
//   max_count    inclusive upper band limit, sampled when the result latches
//   count_out    edge count of the last completed window
//   count_valid  one-cycle strobe with each fresh count_out
//   overflow     last completed window saturated the counter
//   in_range     last completed window was inside the band and not saturated
//   busy         a window is being gated or latched
// -----------------------------------------------------------------------------
module pulse_rate_meter
  import pulse_rate_meter_pkg::*;
#(
  parameter int GATE_CYCLES = GATE_CYCLES_1S,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_224hz,
  input  logic             clear,
  input  logic             enable,
  input  logic             pulse_in,
  input  logic [CNT_W-1:0] min_count,
  input  logic [CNT_W-1:0] max_count,
  output logic [CNT_W-1:0] count_out,
  output logic             count_valid,
  output logic             overflow,
  output logic             in_range,
  output logic             busy
);

  localparam int               GW        = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_start;
  logic             w_latch;
  logic             w_sync;
  logic             w_rise;
  logic             w_edge;
  logic [GW-1:0]    r_gate_cnt;
  logic [CNT_W-1:0] r_edge_cnt;
  logic             r_ovf;
  logic [CNT_W-1:0] r_count_out;
  logic             r_count_valid;
  logic             r_overflow;
  logic             r_in_range;

  pulse_rate_meter_edge_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_edge_sync (
    .i_clk   (clk_224hz),
    .i_clear (clear),
    .i_pulse (pulse_in),
    .o_sync  (w_sync),
    .o_rise  (w_rise)
  );

  // Counted edge: synchronized level high, history low, window open.
  assign w_edge = (r_state == ST_GATE) && w_sync && w_rise;

  // State register
  always_ff @(posedge clk_224hz) begin
    if (clear) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state; w_start re-arms the counters, w_latch publishes the result
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_latch     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (enable) begin
          w_state_nxt = ST_GATE;
          w_start     = 1'b1;
        end
      end
      ST_GATE: begin
        // Dropping enable abandons the window silently.
        if (!enable)                     w_state_nxt = ST_IDLE;
        else if (r_gate_cnt == GATE_LAST) w_state_nxt = ST_LATCH;
      end
      ST_LATCH: begin
        w_latch = 1'b1;
        if (enable) begin
          w_state_nxt = ST_GATE;
          w_start     = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Window counters; the edge count sticks at full scale and flags overflow
  always_ff @(posedge clk_224hz) begin
    if (clear || w_start) begin
      r_gate_cnt <= '0;
      r_edge_cnt <= '0;
      r_ovf      <= 1'b0;
    end else if (r_state == ST_GATE) begin
      r_gate_cnt <= r_gate_cnt + 1'b1;
      if (w_edge) begin
        if (r_edge_cnt == CNT_MAX) r_ovf      <= 1'b1;
        else                       r_edge_cnt <= r_edge_cnt + 1'b1;
      end
    end
  end

  // Result registers, loaded only in the LATCH cycle and held otherwise.
  // An inverted band (min > max) can never satisfy both compares.
  always_ff @(posedge clk_224hz) begin
    if (clear) begin
      r_count_out   <= '0;
      r_count_valid <= 1'b0;
      r_overflow    <= 1'b0;
      r_in_range    <= 1'b0;
    end else begin
      r_count_valid <= w_latch;
      if (w_latch) begin
        r_count_out <= r_edge_cnt;
        r_overflow  <= r_ovf;
        r_in_range  <= (min_count <= r_edge_cnt) && (r_edge_cnt <= max_count) && !r_ovf;
      end
    end
  end

  assign count_out   = r_count_out;
  assign count_valid = r_count_valid;
  assign overflow    = r_overflow;
  assign in_range    = r_in_range;
  assign busy        = (r_state == ST_GATE) || (r_state == ST_LATCH);

endmodule

// File: tb/tb_pulse_rate_meter.sv
// -----------------------------------------------------------------------------
// tb_pulse_rate_meter
// Directed bench for pulse_rate_meter: an 8-bit instance (A) and a 4-bit
// instance (B) share clock, clear, enable and pulse line. Expected values are
// hand-computed from the 224-cycle window and the line periods driven here.
// -----------------------------------------------------------------------------
module tb_pulse_rate_meter;

  logic       clk = 1'b0;
  logic       clear;
  logic       enable;
  logic       pulse_in;
  logic [7:0] min_a, max_a;
  logic [3:0] min_b, max_b;

  logic [7:0] cnt_a;
  logic       cv_a, ovf_a, inr_a, busy_a;
  logic [3:0] cnt_b;
  logic       cv_b, ovf_b, inr_b, busy_b;

  int tests = 0;
  int fails = 0;
  int half  = 0;   // line toggles every 'half' cycles; 0 = hold level
  int ph    = 0;
  int n;
  int strobes;

  always #5 clk = ~clk;

  pulse_rate_meter #(.GATE_CYCLES(224), .CNT_W(8), .SYNC_STAGES(2)) u_dut_a (
    .clk_224hz   (clk),
    .clear       (clear),
    .enable      (enable),
    .pulse_in    (pulse_in),
    .min_count   (min_a),
    .max_count   (max_a),
    .count_out   (cnt_a),
    .count_valid (cv_a),
    .overflow    (ovf_a),
    .in_range    (inr_a),
    .busy        (busy_a)
  );

  pulse_rate_meter #(.GATE_CYCLES(224), .CNT_W(4), .SYNC_STAGES(2)) u_dut_b (
    .clk_224hz   (clk),
    .clear       (clear),
    .enable      (enable),
    .pulse_in    (pulse_in),
    .min_count   (min_b),
    .max_count   (max_b),
    .count_out   (cnt_b),
    .count_valid (cv_b),
    .overflow    (ovf_b),
    .in_range    (inr_b),
    .busy        (busy_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit
  // after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (half != 0) begin
      ph++;
      if (ph >= half) begin
        ph       = 0;
        pulse_in = ~pulse_in;
      end
    end
  endtask

  // Ticks until count_valid of A is seen; returns the tick count or -1.
  task automatic wait_strobe(output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (cv_a !== 1'b1 && cnt < 300);
    if (cv_a !== 1'b1) cnt = -1;
  endtask

  initial begin
    clear    = 1'b1;
    enable   = 1'b1;
    pulse_in = 1'b0;
    half     = 1;
    min_a    = 8'd27;
    max_a    = 8'd29;
    min_b    = 4'd0;
    max_b    = 4'd15;

    // Reset held 3 cycles with enable high and the line toggling
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_valid", 32'(cv_a), 0);
      check("rst_busy", 32'(busy_a), 0);
    end
    check("rst_count", 32'(cnt_a), 0);
    check("rst_overflow", 32'(ovf_a), 0);
    check("rst_in_range", 32'(inr_a), 0);
    check("rst_count_b", 32'(cnt_b), 0);

    // Release: enable sampled at the next edge, strobe 225 edges later
    clear = 1'b0;
    half  = 4;
    wait_strobe(n);
    check("first_strobe_latency", 32'(n), 226);
    check("busy_in_next_window", 32'(busy_a), 1);

    // 28 Hz line
    for (int w = 0; w < 2; w++) begin
      wait_strobe(n);
      check("28hz_period", 32'(n), 225);
      check("28hz_count", 32'(cnt_a), 28);
      check("28hz_in_range", 32'(inr_a), 1);
      check("28hz_overflow", 32'(ovf_a), 0);
    end

    // 7 Hz line; first window after the switch is mixed and skipped
    half = 16;
    tick();
    check("strobe_one_cycle", 32'(cv_a), 0);
    wait_strobe(n);
    wait_strobe(n);
    check("7hz_count", 32'(cnt_a), 7);
    check("7hz_out_of_band", 32'(inr_a), 0);
    min_a = 8'd7;
    max_a = 8'd7;
    wait_strobe(n);
    check("7hz_exact_count", 32'(cnt_a), 7);
    check("7hz_exact_band", 32'(inr_a), 1);
    min_a = 8'd9;
    max_a = 8'd3;
    wait_strobe(n);
    check("7hz_inverted_count", 32'(cnt_a), 7);
    check("7hz_inverted_band", 32'(inr_a), 0);

    // 112 Hz line: B saturates at 15, A counts 112
    half = 1;
    wait_strobe(n);
    wait_strobe(n);
    check("ovf_count_b", 32'(cnt_b), 15);
    check("ovf_flag_b", 32'(ovf_b), 1);
    check("ovf_in_range_b", 32'(inr_b), 0);
    check("ovf_valid_b", 32'(cv_b), 1);
    check("112hz_count_a", 32'(cnt_a), 112);
    check("112hz_overflow_a", 32'(ovf_a), 0);

    // Back to 7 Hz: overflow clears
    half  = 16;
    min_a = 8'd0;
    max_a = 8'd200;
    wait_strobe(n);
    wait_strobe(n);
    check("after_ovf_count_b", 32'(cnt_b), 7);
    check("after_ovf_flag_b", 32'(ovf_b), 0);
    check("after_ovf_in_range_b", 32'(inr_b), 1);
    check("wide_band_in_range_a", 32'(inr_a), 1);

    // Abort at cycle 100 of a window
    repeat (99) tick();
    check("abort_busy_before", 32'(busy_a), 1);
    enable = 1'b0;
    tick();
    check("abort_busy_after", 32'(busy_a), 0);
    min_a   = 8'd100;
    strobes = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (cv_a === 1'b1) strobes++;
    end
    check("abort_no_strobe", 32'(strobes), 0);
    check("abort_hold_count", 32'(cnt_a), 7);
    check("abort_hold_in_range", 32'(inr_a), 1);
    check("abort_hold_overflow", 32'(ovf_a), 0);

    // Clear in mid-window
    enable = 1'b1;
    repeat (50) tick();
    check("midclr_busy_before", 32'(busy_a), 1);
    clear = 1'b1;
    tick();
    check("midclr_count", 32'(cnt_a), 0);
    check("midclr_in_range", 32'(inr_a), 0);
    check("midclr_busy", 32'(busy_a), 0);
    check("midclr_valid", 32'(cv_a), 0);
    check("midclr_count_b", 32'(cnt_b), 0);
    enable = 1'b0;
    tick();
    clear = 1'b0;
    min_a = 8'd0;
    max_a = 8'd200;

    // Line already high when the window opens: only the later rise counts
    half     = 0;
    pulse_in = 1'b1;
    repeat (5) tick();
    enable = 1'b1;
    repeat (20) tick();
    pulse_in = 1'b0;
    repeat (5) tick();
    pulse_in = 1'b1;
    wait_strobe(n);
    check("prehigh_latency", 32'(n), 201);
    check("prehigh_count", 32'(cnt_a), 1);
    check("prehigh_in_range", 32'(inr_a), 1);

    // Rise detected in the last GATE cycle is counted
    pulse_in = 1'b0;
    repeat (221) tick();
    pulse_in = 1'b1;
    wait_strobe(n);
    check("final_cycle_latency", 32'(n), 4);
    check("final_cycle_count", 32'(cnt_a), 1);

    // Rise detected only in the LATCH cycle is lost, also in the next window
    pulse_in = 1'b0;
    repeat (222) tick();
    pulse_in = 1'b1;
    wait_strobe(n);
    check("latch_edge_latency", 32'(n), 3);
    check("latch_edge_count", 32'(cnt_a), 0);
    wait_strobe(n);
    check("held_level_period", 32'(n), 225);
    check("held_level_count", 32'(cnt_a), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
